// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler driving the select of a shared DW-bit
// mux. One winner is picked among NREQ requesters, its word is captured into
// out_data and held under a valid/ready handshake until accepted.
//
// Optional feature, enabled by defining MUX_RR_SCHED_LOCK_EN:
//   adds a 'lock' input giving the current winner burst ownership for up to
//   8 consecutive transfers without advancing the round-robin pointer.
module mux_rr_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    localparam int SW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [SW-1:0]      sel,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
`ifdef MUX_RR_SCHED_LOCK_EN
    ,
    input  logic               lock
`endif
);

    // IDLE waits for a request, ARB is the arbitration step (entered in the
    // same cycle a request is seen, so it never persists as a register value),
    // HOLD keeps the captured word until the consumer accepts it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_r;
    logic [SW-1:0]     ptr_r;
    logic [NREQ-1:0]   gnt_r;
    logic [SW-1:0]     sel_r;
    logic [DW-1:0]     data_r;
    logic              valid_r;
    logic              busy_r;

    logic              accept_s;
    logic [SW:0]       pick_s;
    logic              hit_s;
    logic [SW-1:0]     win_s;
    logic              grant_s;
    logic [SW-1:0]     gidx_s;
    logic [SW-1:0]     ptr_nxt_s;
    logic              lock_go_s;

`ifdef MUX_RR_SCHED_LOCK_EN
    logic [2:0]        burst_r;
    logic [2:0]        burst_nxt_s;
`endif

    // Round-robin search: first set request at or after pointer p, wrapping
    // modulo NREQ. Returns {found, index}.
    function automatic logic [SW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [SW-1:0]   p);
        logic          found;
        logic [SW-1:0] idx;
        logic [SW-1:0] cand;
        found = 1'b0;
        idx   = {SW{1'b0}};
        for (int o = 0; o < NREQ; o++) begin
            cand = SW'((int'(p) + o) % NREQ);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Next pointer after a grant to index i, wrapping NREQ-1 back to 0
    // (NREQ need not be a power of two).
    function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] i);
        if (i == SW'(NREQ - 1)) begin
            return {SW{1'b0}};
        end else begin
            return i + SW'(1);
        end
    endfunction

    assign accept_s = valid_r & out_ready;
    assign pick_s   = rr_pick(req, ptr_r);
    assign hit_s    = pick_s[SW];
    assign win_s    = pick_s[SW-1:0];

`ifdef MUX_RR_SCHED_LOCK_EN
    // Burst re-grant: consumer accepts, lock held, winner still requesting and
    // fewer than 8 transfers in the current burst.
    assign lock_go_s = (state_r == ST_HOLD) && accept_s && lock &&
                       req[sel_r] && (burst_r != 3'd7);
`else
    assign lock_go_s = 1'b0;
`endif

    // Decide whether a grant is issued at the next edge, to whom, and how the
    // pointer (and burst counter) moves.
    always_comb begin
        grant_s   = 1'b0;
        gidx_s    = win_s;
        ptr_nxt_s = ptr_r;
`ifdef MUX_RR_SCHED_LOCK_EN
        burst_nxt_s = burst_r;
`endif
        case (state_r)
            ST_IDLE, ST_ARB: begin
                if (hit_s) begin
                    grant_s   = 1'b1;
                    gidx_s    = win_s;
                    ptr_nxt_s = ptr_inc(win_s);
`ifdef MUX_RR_SCHED_LOCK_EN
                    burst_nxt_s = 3'd0;
`endif
                end else begin
                    grant_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (lock_go_s) begin
                    grant_s   = 1'b1;
                    gidx_s    = sel_r;
                    ptr_nxt_s = ptr_r;
`ifdef MUX_RR_SCHED_LOCK_EN
                    burst_nxt_s = burst_r + 3'd1;
`endif
                end else if (accept_s && hit_s) begin
                    grant_s   = 1'b1;
                    gidx_s    = win_s;
                    ptr_nxt_s = ptr_inc(win_s);
`ifdef MUX_RR_SCHED_LOCK_EN
                    burst_nxt_s = 3'd0;
`endif
                end else begin
                    grant_s = 1'b0;
                end
            end
            default: begin
                grant_s = 1'b0;
            end
        endcase
    end

    // Scheduler state and registered outputs; reset has priority over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= {SW{1'b0}};
            gnt_r   <= {NREQ{1'b0}};
            sel_r   <= {SW{1'b0}};
            data_r  <= {DW{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else if (grant_s) begin
            state_r <= ST_HOLD;
            ptr_r   <= ptr_nxt_s;
            gnt_r   <= {{(NREQ-1){1'b0}}, 1'b1} << gidx_s;
            sel_r   <= gidx_s;
            data_r  <= req_data[gidx_s*DW +: DW];
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
        end else if ((state_r != ST_HOLD) || accept_s) begin
            state_r <= ST_IDLE;
            gnt_r   <= {NREQ{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            gnt_r   <= {NREQ{1'b0}};
        end
    end

`ifdef MUX_RR_SCHED_LOCK_EN
    // Burst length counter for locked ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_r <= 3'd0;
        end else begin
            burst_r <= burst_nxt_s;
        end
    end
`endif

    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;

endmodule
